regfile_wb_arbiter: RTL and testbench

//  Owns the single write port of the 32x32 register file (RW/DR/Data_in).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_wb_arbiter_if.sv | 26 ++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback path.
package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   word_t;

endpackage : regfile_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: NREQ requesters, each with valid/ready, dest register and data.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 2
);
    import regfile_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*REG_AW-1:0] req_dr;
    logic [NREQ*XLEN-1:0]   req_data;

    modport master (
        output req_valid,
        output req_dr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dr,
        input  req_data,
        output req_ready
    );

endinterface : regfile_wb_arbiter_if

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer and wraps.
// The pointer moves to just past the granted requester when advance is high.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_r;
    logic [PW-1:0] ptr_nxt_s;
    logic          found_s;

    // Grant the first requester at or after the pointer, wrapping modulo N.
    always_comb begin
        gnt       = '0;
        ptr_nxt_s = ptr_r;
        found_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr_r) + k) % N;
            if (!found_s && req[idx]) begin
                gnt[idx]  = 1'b1;
                found_s   = 1'b1;
                ptr_nxt_s = PW'((idx + 1) % N);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Priority pointer: only moves when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: round-robin writeback arbitration, a registered
// write stage toward the register file, and a per-register busy scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   wb,
    input  logic                  rsv_valid,
    input  reg_addr_t             rsv_dr,
    output logic                  rsv_ready,
    input  reg_addr_t             chk_rs1,
    input  reg_addr_t             chk_rs2,
    output logic                  hazard,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  rf_rw,
    output reg_addr_t             rf_dr,
    output word_t                 rf_data
);

    logic [NREQ-1:0]     gnt_s;
    logic                xfer_s;
    reg_addr_t           sel_dr_s;
    word_t               sel_data_s;
    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_nxt_s;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (wb.req_valid),
        .advance (xfer_s),
        .gnt     (gnt_s)
    );

    // Ready is masked while reset is asserted so nothing can be accepted then.
    assign wb.req_ready = gnt_s & {NREQ{rst_n}};
    assign xfer_s       = |wb.req_ready;

    // One-hot AND-OR mux of the granted requester's destination and data.
    always_comb begin
        sel_dr_s   = '0;
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                sel_dr_s   = sel_dr_s   | wb.req_dr[i*REG_AW +: REG_AW];
                sel_data_s = sel_data_s | wb.req_data[i*XLEN +: XLEN];
            end else begin
                sel_dr_s   = sel_dr_s;
                sel_data_s = sel_data_s;
            end
        end
    end

    // Write stage: pulse rf_rw for one cycle per transfer; dr/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_rw   <= 1'b0;
            rf_dr   <= '0;
            rf_data <= '0;
        end else if (xfer_s) begin
            rf_rw   <= 1'b1;
            rf_dr   <= sel_dr_s;
            rf_data <= sel_data_s;
        end else begin
            rf_rw   <= 1'b0;
            rf_dr   <= rf_dr;
            rf_data <= rf_data;
        end
    end

    // Scoreboard next state: clear on commit first, so a same-edge reservation wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (rf_rw) begin
            busy_nxt_s[rf_dr] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (rsv_valid && rsv_ready) begin
            busy_nxt_s[rsv_dr] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Issue-side views use busy before any clear at the coming edge (no bypass).
    assign busy      = busy_r;
    assign rsv_ready = ~busy_r[rsv_dr];
    assign hazard    = busy_r[chk_rs1] | busy_r[chk_rs2];

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural model of the writeback rules.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREQ(NREQ)) wb ();

    logic                rsv_valid;
    reg_addr_t           rsv_dr;
    logic                rsv_ready;
    reg_addr_t           chk_rs1;
    reg_addr_t           chk_rs2;
    logic                hazard;
    logic [NUM_REGS-1:0] busy;
    logic                rf_rw;
    reg_addr_t           rf_dr;
    word_t               rf_data;

    regfile_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb        (wb.slave),
        .rsv_valid (rsv_valid),
        .rsv_dr    (rsv_dr),
        .rsv_ready (rsv_ready),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .hazard    (hazard),
        .busy      (busy),
        .rf_rw     (rf_rw),
        .rf_dr     (rf_dr),
        .rf_data   (rf_data)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int                  m_p;
    bit [NUM_REGS-1:0]   m_busy;
    bit                  m_rw;
    bit [REG_AW-1:0]     m_dr;
    bit [XLEN-1:0]       m_data;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p = 0; m_busy = '0; m_rw = 1'b0; m_dr = '0; m_data = '0;
    endtask

    task automatic set_req(input int i, input bit v, input bit [REG_AW-1:0] d, input bit [XLEN-1:0] x);
        wb.req_valid[i]                = v;
        wb.req_dr[i*REG_AW +: REG_AW]  = d;
        wb.req_data[i*XLEN +: XLEN]    = x;
    endtask

    task automatic idle_inputs();
        wb.req_valid = '0; wb.req_dr = '0; wb.req_data = '0;
        rsv_valid = 1'b0; rsv_dr = '0; chk_rs1 = '0; chk_rs2 = '0;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model at the
    // edge, then check the registered outputs just after the edge.
    task automatic cycle();
        int g;
        logic [NREQ-1:0] er;
        bit rr;
        bit [NUM_REGS-1:0] nb;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_p + k) % NREQ;
            if (g < 0 && wb.req_valid[idx]) g = idx;
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        rr = !m_busy[rsv_dr];
        @(negedge clk);
        check_eq("req_ready", wb.req_ready, er);
        check_eq("rsv_ready", rsv_ready, rr);
        check_eq("hazard", hazard, m_busy[chk_rs1] | m_busy[chk_rs2]);
        @(posedge clk);
        nb = m_busy;
        if (m_rw) nb[m_dr] = 1'b0;
        if (rsv_valid && rr) nb[rsv_dr] = 1'b1;
        m_busy = nb;
        if (g >= 0) begin
            m_rw   = 1'b1;
            m_dr   = wb.req_dr[g*REG_AW +: REG_AW];
            m_data = wb.req_data[g*XLEN +: XLEN];
            m_p    = (g + 1) % NREQ;
        end else begin
            m_rw = 1'b0;
        end
        #1;
        check_eq("rf_rw", rf_rw, m_rw);
        check_eq("rf_dr", rf_dr, m_dr);
        check_eq("rf_data", rf_data, m_data);
        check_eq("busy", busy, m_busy);
    endtask

    // Asynchronous reset from the post-edge phase; returns in the same phase.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_rf_rw", rf_rw, 1'b0);
        check_eq("rst_rf_dr", rf_dr, 5'd0);
        check_eq("rst_rf_data", rf_data, 32'd0);
        check_eq("rst_busy", busy, 32'd0);
        check_eq("rst_req_ready", wb.req_ready, 2'b00);
        @(posedge clk); #1;
        check_eq("rst_hold_rw", rf_rw, 1'b0);
        idle_inputs();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_rw", rf_rw, 1'b0);
        check_eq("post_rst_busy", busy, 32'd0);
        model_reset();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("init_busy", busy, 32'd0);
        check_eq("init_rf_rw", rf_rw, 1'b0);

        // 1. reset mid-stream with rf_rw=1 and busy=0x210
        rsv_valid = 1'b1; rsv_dr = 5'd4;
        cycle();
        rsv_dr = 5'd9; set_req(0, 1'b1, 5'd1, 32'h1111_2222);
        cycle();
        check_eq("t1_busy", busy, 32'h0000_0210);
        check_eq("t1_rw", rf_rw, 1'b1);
        rsv_valid = 1'b0;
        do_reset();

        // 2. single write
        set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        cycle();
        check_eq("t2_rw", rf_rw, 1'b1);
        check_eq("t2_dr", rf_dr, 5'd5);
        check_eq("t2_data", rf_data, 32'hDEAD_BEEF);
        idle_inputs();
        cycle();
        check_eq("t2_rw_off", rf_rw, 1'b0);
        do_reset();

        // 3. round-robin fairness
        set_req(0, 1'b1, 5'd3, 32'hA0A0_0003);
        set_req(1, 1'b1, 5'd7, 32'hB0B0_0007);
        for (int k = 0; k < 6; k++) begin
            cycle();
            check_eq("t3_rr_dr", rf_dr, (k % 2 == 0) ? 5'd3 : 5'd7);
        end
        set_req(0, 1'b0, 5'd3, 32'hA0A0_0003);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("t3_solo_dr", rf_dr, 5'd7);
            check_eq("t3_solo_rw", rf_rw, 1'b1);
        end
        idle_inputs();
        cycle();
        cycle();

        // 4. reservation and hazard
        rsv_valid = 1'b1; rsv_dr = 5'd9;
        cycle();
        rsv_valid = 1'b0; chk_rs1 = 5'd9;
        cycle();
        check_eq("t4_hazard", hazard, 1'b1);
        check_eq("t4_rsv_block", rsv_ready, 1'b0);
        set_req(0, 1'b1, 5'd9, 32'h0000_0099);
        cycle();
        check_eq("t4_commit_dr", rf_dr, 5'd9);
        check_eq("t4_hazard_hold", hazard, 1'b1);
        set_req(0, 1'b0, 5'd9, 32'h0000_0099);
        cycle();
        check_eq("t4_hazard_drop", hazard, 1'b0);
        idle_inputs();

        // 5. simultaneous set/clear
        rsv_valid = 1'b1; rsv_dr = 5'd4;
        cycle();
        rsv_valid = 1'b0; set_req(0, 1'b1, 5'd4, 32'h4444_0001);
        cycle();
        set_req(0, 1'b0, 5'd4, 32'h4444_0001); rsv_valid = 1'b1;
        cycle();
        check_eq("t5_cleared", busy[4], 1'b0);
        cycle();
        check_eq("t5_reset_rsv", busy[4], 1'b1);
        rsv_valid = 1'b0; wb.req_valid = 2'b11;
        set_req(1, 1'b1, 5'd4, 32'h4444_0002);
        set_req(0, 1'b1, 5'd4, 32'h4444_0002);
        cycle();
        idle_inputs();
        cycle();
        check_eq("t5_free", busy[4], 1'b0);
        set_req(0, 1'b1, 5'd4, 32'h4444_0003);
        cycle();
        idle_inputs(); rsv_valid = 1'b1; rsv_dr = 5'd4;
        cycle();
        check_eq("t5_set_wins", busy[4], 1'b1);
        idle_inputs();

        // 6. idle hold and unreserved write to r0
        set_req(1, 1'b1, 5'd12, 32'h0000_1234);
        cycle();
        idle_inputs();
        cycle();
        cycle();
        check_eq("t6_idle_rw", rf_rw, 1'b0);
        check_eq("t6_hold_dr", rf_dr, 5'd12);
        check_eq("t6_hold_data", rf_data, 32'h0000_1234);
        set_req(0, 1'b1, 5'd0, 32'h0BAD_F00D);
        cycle();
        check_eq("t6_r0_rw", rf_rw, 1'b1);
        check_eq("t6_r0_dr", rf_dr, 5'd0);
        idle_inputs();
        cycle();
        check_eq("t6_busy_same", busy, 32'h0000_0010);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_dr    = 5'($urandom_range(0, 31));
            chk_rs1   = 5'($urandom_range(0, 31));
            chk_rs2   = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
